moore_pattern_tx: RTL

MOORE_PATTERN_TX -- requirements
Module: moore_pattern_tx

---
 rtl/moore_pattern_tx.sv | 81 ++++++++
 1 files changed

// File: rtl/moore_pattern_tx.sv
// moore_pattern_tx: sends PATTERN MSB first reps times, GAP idle zeros between words, then a done pulse.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit to every word.
module moore_pattern_tx #(
    parameter int              PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b11010,
    parameter int              GAP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] reps,
    output logic       x_out,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
`ifdef PATTERN_TX_PARITY_EN
    localparam int WORD_W = PAT_W + 1;
`else
    localparam int WORD_W = PAT_W;
`endif
    localparam logic [4:0] LAST     = 5'(WORD_W - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    state_t           state, state_nx;
    logic [4:0]       idx, idx_nx;
    logic [3:0]       rem_cnt, rem_nx, gap_cnt, gap_nx;
    logic [PAT_W-1:0] pat_sh;
    logic             bit_nx;
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        rem_nx   = rem_cnt;
        gap_nx   = gap_cnt;
        case (state)
            S_IDLE: if (start && reps != 4'd0) begin
                state_nx = S_SEND;
                rem_nx   = reps;
                idx_nx   = '0;
            end
            S_SEND: if (idx == LAST) begin
                idx_nx = '0;
                gap_nx = '0;
                if (rem_cnt > 4'd1) begin
                    rem_nx   = rem_cnt - 4'd1;
                    state_nx = (GAP == 0) ? S_SEND : S_GAP;
                end else
                    state_nx = S_DONE;
            end else
                idx_nx = idx + 5'd1;
            S_GAP: if (gap_cnt == GAP_LAST) state_nx = S_SEND; else gap_nx = gap_cnt + 4'd1;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state they decode.
    assign pat_sh = PATTERN << idx_nx;
`ifdef PATTERN_TX_PARITY_EN
    assign bit_nx = (idx_nx == 5'(PAT_W)) ? ^PATTERN : pat_sh[PAT_W-1];
`else
    assign bit_nx = pat_sh[PAT_W-1];
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            rem_cnt <= '0;
            gap_cnt <= '0;
            x_out   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            rem_cnt <= rem_nx;
            gap_cnt <= gap_nx;
            x_out   <= (state_nx == S_SEND) && bit_nx;
            busy    <= state_nx != S_IDLE;
            done    <= state_nx == S_DONE;
        end
    end
endmodule
